// File: rtl/jedro_1_shift_pkg.sv
// jedro_1_shift_pkg: shared op/state encodings for the jedro_1 iterative shifter
package jedro_1_shift_pkg;
    localparam int DEFAULT_DATA_WIDTH = 32;
    typedef enum logic [2:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } shift_op_e;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } shift_state_e;
    function automatic logic op_legal(input logic [2:0] op);
        return op <= 3'd4;
    endfunction
endpackage

// File: rtl/jedro_1_shift_step.sv
// jedro_1_shift_step: one combinational shift/rotate pass by amt_i bits
module jedro_1_shift_step
    import jedro_1_shift_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]         value_i,
    input  logic [2:0]                    op_i,
    input  logic                          fill_i,
    input  logic [$clog2(DATA_WIDTH):0]   amt_i,
    output logic [DATA_WIDTH-1:0]         value_o
);
    logic [2*DATA_WIDTH-1:0] rol, ror, sra;
    always_comb begin
        rol = {value_i, value_i} << amt_i;
        ror = {value_i, value_i} >> amt_i;
        sra = {{DATA_WIDTH{fill_i}}, value_i} >> amt_i;
        value_o = op_i == OP_SLL ? value_i << amt_i :
                  op_i == OP_SRL ? value_i >> amt_i :
                  op_i == OP_SRA ? sra[DATA_WIDTH-1:0] :
                  op_i == OP_ROL ? rol[2*DATA_WIDTH-1:DATA_WIDTH] :
                  op_i == OP_ROR ? ror[DATA_WIDTH-1:0] : value_i;
    end
endmodule

// File: rtl/jedro_1_iter_shifter.sv
// jedro_1_iter_shifter: multi-cycle shift/rotate unit, up to STEP bits per clock
module jedro_1_iter_shifter
    import jedro_1_shift_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int STEP = 1,
    localparam int SHAMT_W = $clog2(DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [SHAMT_W-1:0]    shamt_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  illegal_o,
    output logic                  busy_o
);
    localparam logic [SHAMT_W:0] STEP_K = (SHAMT_W+1)'(STEP);
    shift_state_e state_q, state_d;
    logic [DATA_WIDTH-1:0] work_q, work_d, step_out;
    logic [2:0] op_q, op_d;
    logic fill_q, fill_d, illegal_q, illegal_d, accept;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [SHAMT_W:0] k;

    jedro_1_shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .value_i (work_q),
        .op_i    (op_q),
        .fill_i  (fill_q),
        .amt_i   (k),
        .value_o (step_out)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= ST_IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) state_d = ST_IDLE;
        else case (state_q)
            ST_IDLE:  if (in_valid_i) state_d = (shamt_i == '0 || !op_legal(op_i)) ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if ({1'b0, rem_q} == k) state_d = ST_DONE;
            ST_DONE:  if (out_ready_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = state_q == ST_IDLE && !flush_i;
        out_valid_o = state_q == ST_DONE;
        busy_o      = state_q != ST_IDLE;
        result_o    = work_q;
        illegal_o   = illegal_q;
    end

    // k = min(STEP, remaining); the final pass lands exactly on zero
    always_comb begin
        accept    = state_q == ST_IDLE && !flush_i && in_valid_i;
        k         = {1'b0, rem_q} > STEP_K ? STEP_K : {1'b0, rem_q};
        work_d    = accept ? data_i : state_q == ST_SHIFT ? step_out : work_q;
        op_d      = accept ? op_i : op_q;
        fill_d    = accept ? data_i[DATA_WIDTH-1] : fill_q;
        rem_d     = accept ? shamt_i : state_q == ST_SHIFT ? rem_q - k[SHAMT_W-1:0] : rem_q;
        illegal_d = accept ? !op_legal(op_i) : illegal_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            work_q    <= '0;
            op_q      <= '0;
            fill_q    <= 1'b0;
            rem_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            work_q    <= work_d;
            op_q      <= op_d;
            fill_q    <= fill_d;
            rem_q     <= rem_d;
            illegal_q <= illegal_d;
        end
    end
endmodule

// File: tb/tb_jedro_1_iter_shifter.sv
// tb_jedro_1_iter_shifter: directed checks of STEP=1 and STEP=8 shifters side by side
module tb_jedro_1_iter_shifter;
    import jedro_1_shift_pkg::*;
    logic clk = 1'b0, rstn = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [2:0] op = '0;
    logic [31:0] data = '0;
    logic [4:0] shamt = '0;
    logic in_ready, out_valid, illegal, busy;
    logic in_ready8, out_valid8, illegal8, busy8;
    logic [31:0] result, result8;
    int checks = 0, failures = 0;
    logic seen;

    always #5 clk = ~clk;

    jedro_1_iter_shifter #(.DATA_WIDTH(32), .STEP(1)) dut (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op_i(op), .data_i(data), .shamt_i(shamt), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .result_o(result), .illegal_o(illegal), .busy_o(busy)
    );

    jedro_1_iter_shifter #(.DATA_WIDTH(32), .STEP(8)) dut8 (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready8),
        .op_i(op), .data_i(data), .shamt_i(shamt), .out_valid_o(out_valid8), .out_ready_i(out_ready),
        .result_o(result8), .illegal_o(illegal8), .busy_o(busy8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int lat(input int sh, input int step, input bit ill);
        return (ill || sh == 0) ? 1 : (sh + step - 1) / step + 1;
    endfunction

    task automatic issue(input string tag, input logic [2:0] o, input logic [31:0] d, input logic [4:0] s);
        @(negedge clk);
        check({tag, "_rdy"}, 32'({in_ready, in_ready8}), 3);
        in_valid = 1'b1;
        op = o;
        data = d;
        shamt = s;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input logic [31:0] exp, input bit ill, input int sh);
        bit s1 = 0, s8 = 0;
        int l1 = 0, l8 = 0;
        logic [31:0] r1 = 'x, r8 = 'x;
        logic i1 = 1'bx, i8 = 1'bx;
        for (int n = 1; n <= 100 && !(s1 && s8); n++) begin
            if (!s1 && out_valid) begin s1 = 1; l1 = n; r1 = result; i1 = illegal; end
            if (!s8 && out_valid8) begin s8 = 1; l8 = n; r8 = result8; i8 = illegal8; end
            if (!(s1 && s8)) begin @(posedge clk); #1; end
        end
        check({tag, "_res"}, r1, exp);
        check({tag, "_ill"}, 32'(i1), 32'(ill));
        check({tag, "_lat"}, l1, lat(sh, 1, ill));
        check({tag, "_res8"}, r8, exp);
        check({tag, "_ill8"}, 32'(i8), 32'(ill));
        check({tag, "_lat8"}, l8, lat(sh, 8, ill));
        @(posedge clk);
        #1;
    endtask

    task automatic op_test(input string tag, input logic [2:0] o, input logic [31:0] d, input logic [4:0] s,
                           input logic [31:0] exp, input bit ill);
        issue(tag, o, d, s);
        collect(tag, exp, ill, ill ? 0 : int'(s));
    endtask

    task automatic watch_quiet(input string tag);
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1 seen = seen | out_valid | out_valid8;
        end
        check(tag, 32'(seen), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'({in_ready, in_ready8}), 3);
        check("rst_valid", 32'({out_valid, out_valid8}), 0);
        check("rst_result", result | result8, 0);
        check("rst_illegal", 32'({illegal, illegal8}), 0);
        check("rst_busy", 32'({busy, busy8}), 0);
        @(negedge clk) rstn = 1'b1;

        op_test("sra6", OP_SRA, 32'h0000_0040, 5'd6, 32'h0000_0001, 0);
        op_test("sra31", OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 0);
        op_test("ror1", OP_ROR, 32'h0000_0001, 5'd1, 32'h8000_0000, 0);
        op_test("rol4", OP_ROL, 32'h8000_0001, 5'd4, 32'h0000_0018, 0);
        op_test("srl31", OP_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001, 0);
        op_test("sll0", OP_SLL, 32'h1234_5678, 5'd0, 32'h1234_5678, 0);
        op_test("illegal6", 3'd6, 32'hDEAD_BEEF, 5'd5, 32'hDEAD_BEEF, 1);
        op_test("sra4neg", OP_SRA, 32'hF000_0000, 5'd4, 32'hFF00_0000, 0);
        op_test("rol31", OP_ROL, 32'h0000_0001, 5'd31, 32'h8000_0000, 0);
        op_test("sll13", OP_SLL, 32'h0000_00FF, 5'd13, 32'h001F_E000, 0);

        out_ready = 1'b0;
        issue("bp", OP_SLL, 32'h0000_0001, 5'd2);
        for (int n = 0; n < 50 && !out_valid; n++) begin @(posedge clk); #1; end
        check("bp_done", 32'(out_valid), 1);
        @(negedge clk);
        in_valid = 1'b1;
        op = OP_SRL;
        data = 32'h0000_0080;
        shamt = 5'd3;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_hold_res", result, 32'h0000_0004);
            check("bp_hold_vld", 32'({out_valid, out_valid8}), 3);
            check("bp_hold_rdy", 32'({in_ready, in_ready8}), 0);
        end
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_bubble_vld", 32'({out_valid, out_valid8}), 0);
        check("bp_bubble_rdy", 32'({in_ready, in_ready8}), 3);
        @(posedge clk);
        #1 in_valid = 1'b0;
        collect("bp_next", 32'h0000_0010, 0, 3);

        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1;
        op = OP_SLL;
        data = 32'h0000_0005;
        shamt = 5'd1;
        #1 check("fl_rdy_low", 32'({in_ready, in_ready8}), 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("fl_no_accept", 32'({busy, busy8}), 0);
        check("fl_rdy_back", 32'({in_ready, in_ready8}), 3);

        issue("abort_fl", OP_SRA, 32'h8000_0000, 5'd20);
        repeat (2) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        #1;
        check("abort_fl_busy", 32'({busy, busy8}), 0);
        check("abort_fl_rdy", 32'({in_ready, in_ready8}), 3);
        watch_quiet("abort_fl_quiet");
        op_test("after_fl", OP_SLL, 32'h0000_0001, 5'd4, 32'h0000_0010, 0);

        issue("abort_rst", OP_SRA, 32'h8000_0000, 5'd20);
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b0;
        #1;
        check("abort_rst_busy", 32'({busy, busy8}), 0);
        check("abort_rst_vld", 32'({out_valid, out_valid8}), 0);
        check("abort_rst_res", result | result8, 0);
        check("abort_rst_rdy", 32'({in_ready, in_ready8}), 3);
        @(negedge clk) rstn = 1'b1;
        watch_quiet("abort_rst_quiet");
        op_test("after_rst", OP_SLL, 32'h0000_0001, 5'd4, 32'h0000_0010, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
